// File: rtl/nibble_serial_addsub.sv
// Serial add/subtract that runs one shared 4-bit slice over NIBBLES nibbles, LSB nibble first.
// Latency: start accepted at edge k -> done and result after edge k+NIBBLES, ready again after edge k+NIBBLES+1.
// Backpressure: start is taken only while ready=1; a start while busy or done is dropped, not queued.
module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_clear,
    input  logic                   i_sub,
    input  logic [4*NIBBLES-1:0]   i_a,
    input  logic [4*NIBBLES-1:0]   i_b,
    output logic                   o_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [4*NIBBLES-1:0]   o_result,
    output logic                   o_cout,
    output logic                   o_v,
    output logic                   o_z
);

    localparam int              W        = 4 * NIBBLES;
    localparam int              IW       = $clog2(NIBBLES);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Latched operation.
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;

    // Inter-nibble carry and nibble index.
    logic            r_carry;
    logic [IW-1:0]   r_idx;

    // Upper nibbles already computed; the current slice output completes the word.
    logic [W-5:0]    r_partial;

    // Committed result and flags.
    logic [W-1:0]    r_result;
    logic            r_cout;
    logic            r_v;
    logic            r_z;

    // Control strobes from the FSM.
    logic            w_launch;
    logic            w_step;
    logic            w_finish;
    logic            w_last;

    // Slice datapath.
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [3:0]      w_b_inv;
    logic            w_cin;
    logic [3:0]      w_sum;
    logic            w_c3;
    logic            w_c4;
    logic [W-1:0]    w_full;

    assign w_last = (r_idx == LAST_IDX);

    // State register; reset returns to IDLE at once, even mid-operation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs; clear beats start in IDLE and aborts RUN.
    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        w_launch    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_start && !i_clear) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (i_clear) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Result is already committed, so clear cannot cut this pulse short.
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pick the nibble pair addressed by the index.
    always_comb begin
        w_a_nib = 4'h0;
        w_b_nib = 4'h0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IW'(n)) begin
                w_a_nib = r_a[4*n +: 4];
                w_b_nib = r_b[4*n +: 4];
            end
        end
    end

    // 4-bit slice, split at bit 3 so the carry into the top bit is available for overflow.
    always_comb begin
        w_b_inv         = w_b_nib ^ {4{r_sub}};
        w_cin           = (r_idx == '0) ? r_sub : r_carry;
        {w_c3, w_sum[2:0]} = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_inv[2:0]} + {3'b000, w_cin};
        {w_c4, w_sum[3]}   = {1'b0, w_a_nib[3]} + {1'b0, w_b_inv[3]} + {1'b0, w_c3};
        w_full          = {w_sum, r_partial};
    end

    // Operand capture on an accepted start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sub <= 1'b0;
        end else if (w_launch) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_sub <= i_sub;
        end
    end

    // Carry chain and nibble index; the index parks on the last nibble instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_launch) begin
            r_carry <= i_sub;
            r_idx   <= '0;
        end else if (w_step) begin
            r_carry <= w_c4;
            if (!w_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Partial result shifts right so each new nibble enters at the top.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_partial <= '0;
        end else if (w_launch) begin
            r_partial <= '0;
        end else if (w_step) begin
            r_partial <= w_full[W-1:4];
        end
    end

    // Commit result and flags only when the last nibble completes; aborts leave them untouched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_v      <= 1'b0;
            r_z      <= 1'b0;
        end else if (w_finish) begin
            r_result <= w_full;
            r_cout   <= w_c4;
            r_v      <= w_c3 ^ w_c4;
            r_z      <= (w_full == '0);
        end
    end

    assign o_result = r_result;
    assign o_cout   = r_cout;
    assign o_v      = r_v;
    assign o_z      = r_z;

endmodule
